// File: rtl/pwm_ramp_ctrl.sv
// Slew-limited sign-magnitude command sequencer feeding the PWM generator, with dead time on reversal.
// Optional command watchdog compiled in with `define PWM_RAMP_WDOG_EN.
module pwm_ramp_ctrl #(
  parameter int STEP_SIZE  = 4,
  parameter int UPDATE_DIV = 64,
  parameter int DEAD_TICKS = 2,
  parameter int WDOG_TICKS = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_val,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] pwm_val,
  output logic       at_target,
  output logic       wdog_trip,
  output logic [1:0] state_dbg
);

  // Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready;
  // cmd_ready is a registered decode of the next state (low only in DEAD) and
  // does not depend on cmd_valid. The sender holds cmd_val stable while valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int DIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(UPDATE_DIV - 1);
  localparam logic [7:0]       STEP      = 8'(STEP_SIZE);
  localparam logic [7:0]       DEAD_INIT = 8'(DEAD_TICKS);

  state_t           state_q, state_n;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       target_q, target_n;
  logic [7:0]       dead_q, dead_n;
  logic [7:0]       pwm_n;
  logic [7:0]       pm, tm, diff, step_amt;
  logic             tick, accept, stay_dead, match;

  assign tick      = (div_q == DIV_LAST);
  assign accept    = cmd_valid && cmd_ready;
  assign state_dbg = state_q;

`ifdef PWM_RAMP_WDOG_EN
  logic [15:0] wdog_q, wdog_n;
  logic        trip_n;
`endif

  always_comb begin
    pwm_n     = pwm_val;
    dead_n    = dead_q;
    stay_dead = 1'b0;
    pm        = {1'b0, pwm_val[6:0]};
    tm        = {1'b0, target_q[6:0]};
    diff      = 8'd0;
    step_amt  = 8'd0;

    // The step always uses the target held before this edge.
    if (tick) begin
      case (state_q)
        RAMP: begin
          if (pwm_val[7] == target_q[7] || tm == 8'd0) begin
            diff     = (pm < tm) ? (tm - pm) : (pm - tm);
            step_amt = (diff < STEP) ? diff : STEP;
            pwm_n[6:0] = (pm < tm) ? 7'(pm + step_amt) : 7'(pm - step_amt);
          end else if (pm != 8'd0) begin
            step_amt   = (pm < STEP) ? pm : STEP;
            pwm_n[6:0] = 7'(pm - step_amt);
            if (pm == step_amt && DEAD_TICKS != 0) begin
              stay_dead = 1'b1;
              dead_n    = DEAD_INIT;
            end
          end else if (DEAD_TICKS == 0) begin
            pwm_n[7] = target_q[7];
          end else begin
            stay_dead = 1'b1;
            dead_n    = DEAD_INIT;
          end
        end
        DEAD: begin
          if (dead_q <= 8'd1) begin
            dead_n   = 8'd0;
            pwm_n[7] = target_q[7];
          end else begin
            dead_n    = dead_q - 8'd1;
            stay_dead = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (state_q == DEAD) begin
      stay_dead = 1'b1;
    end

    // A zero-magnitude target keeps its previous dir bit.
    target_n = target_q;
    if (accept)
      target_n = (cmd_val[6:0] == 7'd0) ? {target_q[7], 7'd0} : cmd_val;

`ifdef PWM_RAMP_WDOG_EN
    wdog_n = wdog_q;
    trip_n = wdog_trip;
    if (accept) begin
      wdog_n = 16'd0;
      trip_n = 1'b0;
    end else if (tick && !wdog_trip) begin
      wdog_n = wdog_q + 16'd1;
      if (wdog_n == 16'(WDOG_TICKS)) begin
        trip_n   = 1'b1;
        target_n = {target_q[7], 7'd0};
      end
    end
`endif

    match = (pwm_n[6:0] == target_n[6:0]) &&
            (target_n[6:0] == 7'd0 || pwm_n[7] == target_n[7]);
    if (stay_dead)  state_n = DEAD;
    else if (match) state_n = IDLE;
    else            state_n = RAMP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      target_q  <= 8'h00;
      dead_q    <= 8'd0;
      pwm_val   <= 8'h00;
      cmd_ready <= 1'b1;
      at_target <= 1'b1;
    end else begin
      state_q   <= state_n;
      div_q     <= tick ? '0 : div_q + 1'b1;
      target_q  <= target_n;
      dead_q    <= dead_n;
      pwm_val   <= pwm_n;
      cmd_ready <= (state_n != DEAD);
      at_target <= (state_n == IDLE);
    end
  end

`ifdef PWM_RAMP_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q    <= 16'd0;
      wdog_trip <= 1'b0;
    end else begin
      wdog_q    <= wdog_n;
      wdog_trip <= trip_n;
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

endmodule
